// File: rtl/instr_mem_banked.sv
// instr_mem_banked: multi-channel, line-wide instruction memory.
// Round-robin arbitration grants one line request per cycle. Each granted
// request returns a full line RD_LAT cycles later. A word-wide program-load
// write port takes priority over reads.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, err_inject port).
module instr_mem_banked #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4096,
    parameter int LINE_WORDS = 4,
    parameter int NUM_CH     = 2,
    parameter int RD_LAT     = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   req_valid,
    output logic [NUM_CH-1:0]                   req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]            req_addr,
    output logic [NUM_CH-1:0]                   resp_valid,
    output logic [NUM_CH*LINE_WORDS*DATA_W-1:0] resp_data,
    output logic [NUM_CH-1:0]                   resp_err,
    input  logic                                wr_en,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]                   wr_data
`ifdef IMEM_PARITY_EN
    ,
    input  logic                                err_inject
`endif
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int SH     = (RD_LAT > 1) ? RD_LAT - 1 : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef IMEM_PARITY_EN
    logic              r_par [DEPTH];
`endif

    logic [CH_W-1:0]         r_ptr;
    int unsigned             w_j;
    logic [NUM_CH-1:0]       w_vshift;
    logic [NUM_CH*ADDR_W-1:0] w_ashift;
    logic                    w_found;
    logic                    w_xfer;
    logic [CH_W-1:0]         w_sel_p0;
    logic [ADDR_W-1:0]       w_addr_p0;
    logic [ADDR_W-1:0]       w_base_p0;
    logic [MEM_AW-1:0]       w_idx;
    logic [LINE_W-1:0]       w_line_p0;
    logic                    w_err_p0;

    logic                    w_vld_fin;
    logic [CH_W-1:0]         w_ch_fin;
    logic [LINE_W-1:0]       w_line_fin;
    logic                    w_err_fin;

    // Round-robin search from r_ptr; writes and reset suppress every grant.
    always_comb begin
        w_found   = 1'b0;
        w_sel_p0  = '0;
        w_addr_p0 = '0;
        w_j       = 0;
        w_vshift  = '0;
        w_ashift  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j      = (int'(r_ptr) + i) % NUM_CH;
            w_vshift = req_valid >> w_j;
            w_ashift = req_addr >> (w_j * ADDR_W);
            if (!w_found && w_vshift[0]) begin
                w_found   = 1'b1;
                w_sel_p0  = CH_W'(w_j);
                w_addr_p0 = w_ashift[ADDR_W-1:0];
            end
        end
        w_xfer    = w_found && !wr_en && !rst;
        req_ready = w_xfer ? (NUM_CH'(1) << w_sel_p0) : '0;
    end

    // Line read for the granted address; out-of-range lines return zero with err.
    always_comb begin
        w_base_p0 = w_addr_p0 & LINE_MASK;
        w_err_p0  = ({1'b0, w_base_p0} >= DEPTH_X);
        w_line_p0 = '0;
        w_idx     = '0;
        if (!w_err_p0) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                w_idx = w_base_p0[MEM_AW-1:0] + MEM_AW'(k);
                w_line_p0[k*DATA_W +: DATA_W] = r_mem[w_idx];
`ifdef IMEM_PARITY_EN
                if ((^r_mem[w_idx]) != r_par[w_idx]) begin
                    w_err_p0 = 1'b1;
                end
`endif
            end
        end
    end

    // Program-load write: ignored in reset, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
            r_mem[wr_addr[MEM_AW-1:0]] <= wr_data;
`ifdef IMEM_PARITY_EN
            r_par[wr_addr[MEM_AW-1:0]] <= (^wr_data) ^ err_inject;
`endif
        end
    end

    // Arbiter pointer moves past the granted channel after each transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_sel_p0 == CH_W'(NUM_CH - 1)) ? '0 : w_sel_p0 + 1'b1;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign w_vld_fin  = w_xfer;
            assign w_ch_fin   = w_sel_p0;
            assign w_line_fin = w_line_p0;
            assign w_err_fin  = w_err_p0;
        end else begin : g_pipe
            logic              r_vld_p  [SH];
            logic [CH_W-1:0]   r_ch_p   [SH];
            logic [LINE_W-1:0] r_line_p [SH];
            logic              r_err_p  [SH];

            // Stage 1 captures the read at the accept edge; reset drops in-flight valids.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SH; s++) r_vld_p[s] <= 1'b0;
                end else begin
                    r_vld_p[0] <= w_xfer;
                    for (int s = 1; s < SH; s++) r_vld_p[s] <= r_vld_p[s-1];
                end
            end

            // Data side of the pipeline shifts alongside the valids.
            always_ff @(posedge clk) begin
                r_ch_p[0]   <= w_sel_p0;
                r_line_p[0] <= w_line_p0;
                r_err_p[0]  <= w_err_p0;
                for (int s = 1; s < SH; s++) begin
                    r_ch_p[s]   <= r_ch_p[s-1];
                    r_line_p[s] <= r_line_p[s-1];
                    r_err_p[s]  <= r_err_p[s-1];
                end
            end

            assign w_vld_fin  = r_vld_p[SH-1];
            assign w_ch_fin   = r_ch_p[SH-1];
            assign w_line_fin = r_line_p[SH-1];
            assign w_err_fin  = r_err_p[SH-1];
        end
    endgenerate

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        // Final stage: one-cycle strobe per channel, data/err held between responses.
        always_ff @(posedge clk) begin
            if (rst) begin
                resp_valid[c]                  <= 1'b0;
                resp_data[c*LINE_W +: LINE_W]  <= '0;
                resp_err[c]                    <= 1'b0;
            end else begin
                resp_valid[c] <= w_vld_fin && (w_ch_fin == CH_W'(c));
                if (w_vld_fin && (w_ch_fin == CH_W'(c))) begin
                    resp_data[c*LINE_W +: LINE_W] <= w_line_fin;
                    resp_err[c]                   <= w_err_fin;
                end
            end
        end
    end

endmodule

// File: doc/instr_mem_banked.md
# instr_mem_banked

Multi-channel, line-wide instruction memory that replaces the single-port word-fetch memory in the ICACHE subsystem. Up to NUM_CH fetch channels (e.g. per-warp-scheduler I-cache refill ports) issue line requests through a valid/ready handshake. A round-robin arbiter grants one request per cycle, and each granted request returns a full line after a fixed, parametrised pipeline latency. A word-wide write port loads program images at run time and takes priority over reads.

## Interface
Parameters:
- ADDR_W, 16: word address width.
- DATA_W, 32: instruction word width.
- DEPTH, 4096: words stored; multiple of LINE_WORDS, ≤ 2^ADDR_W.
- LINE_WORDS, 4: words per line; power of two, ≥ 1.
- NUM_CH, 2: request channels, ≥ 1.
- RD_LAT, 2: accept-to-response latency in cycles, ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel grant; at most one bit high.
- req_addr  in  NUM_CH*ADDR_W  channel c at [c*ADDR_W +: ADDR_W]; word address.
- resp_valid  out  NUM_CH  one-cycle response strobe per channel.
- resp_data  out  NUM_CH*LINE_WORDS*DATA_W  line per channel; word k of channel c at [(c*LINE_WORDS+k)*DATA_W +: DATA_W].
- resp_err  out  NUM_CH  response error flag, qualified by resp_valid.
- wr_en  in  1  program-load word write.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- err_inject  in  1  present only with IMEM_PARITY_EN; inverts stored parity of the word being written.

## Operation
- Line base = req_addr with low log2(LINE_WORDS) bits cleared. Response word k = mem[base+k].
- Arbiter: round-robin pointer `ptr`. When wr_en=0, grant the first channel with req_valid=1, searching from `ptr` upward modulo NUM_CH. req_ready is asserted combinationally for that channel only.
- Transfer occurs when req_valid&req_ready. After a transfer, `ptr` becomes the granted channel+1 mod NUM_CH. `ptr` is unchanged when there is no transfer.
- wr_en=1 forces req_ready=0 on all channels in that cycle. The write happens only if wr_addr < DEPTH; out-of-range writes are dropped silently.
- Read data is sampled at the accept edge. A write to the same word in the same cycle is impossible (writes block reads). A write in any later cycle does not change an in-flight response.
- Out of range (base ≥ DEPTH): resp_data for that channel is all zero and resp_err=1.
- Requests do not need to be held once accepted. A channel may issue back-to-back requests; responses stay in order per channel.
- There is no response backpressure; the consumer must accept resp_valid whenever it occurs.
- Memory contents are not reset; use $readmemh or the write port to initialise.

## Timing
- Accept at edge T → resp_valid[c] high during cycle T+RD_LAT, for exactly one cycle.
- resp_data[c] and resp_err[c] hold their last value when resp_valid[c]=0.
- Aggregate throughput is one line per cycle. Sustained single-channel throughput is also one line per cycle when there is no contention.
- The pipeline is a RD_LAT-deep shift register carrying {valid, channel, data, err}. The memory read occupies stage 1.
- Reset (rst=1 at an edge):
  - `ptr`=0.
  - All pipeline valids cleared.
  - resp_valid=0, resp_data=0, resp_err=0.
  - req_ready=0 while rst=1.
  - In-flight reads are dropped and produce no response.
  - A wr_en asserted during reset is ignored.
- Simultaneous requests on all channels: grants rotate, so each channel is served once per NUM_CH cycles.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed at write time and XORed with err_inject.
  - On read, a parity mismatch on any word of the line sets resp_err=1. The data is still returned unmodified.
  - The err_inject port exists.
- IMEM_PARITY_EN undefined:
  - No parity storage and no err_inject port.
  - resp_err reflects only the out-of-range condition.

## Test plan
- Reset then single read: write words 0x100..0x103 = 0xA0..0xA3. Ch0 requests addr 0x102 at T → resp_valid[0] at T+2 with words {0xA0,0xA1,0xA2,0xA3}, resp_err=0.
- Contention: NUM_CH=2, both channels hold valid for 4 cycles → grants 0,1,0,1. Responses arrive on alternating channels at T+2..T+5.
- Write priority: wr_en=1 at the same cycle as req_valid[0] → req_ready=0. Grant follows in the next cycle. The response returns the newly written data.
- Out of range: DEPTH=4096, ch1 requests 0x1000 → resp_valid[1], resp_data=0, resp_err=1. A write to 0x1000 leaves mem unchanged.
- Reset mid-flight: accept a request at T, assert rst at T+1 → no resp_valid at T+2, and `ptr` returns to 0.
- IMEM_PARITY_EN: write word 0x200 with err_inject=1, then read line 0x200 → resp_err=1 with correct data. Rewrite the word with err_inject=0 → resp_err=0.
